// File: rtl/bta_operand_sequencer_if.sv
// Stream and adder-side signal bundle for bta_operand_sequencer.
//   in_*   : operand word stream (valid/ready), in_cin sampled with word 0 of a frame
//   ops_*  : parallel operand bus, carry-in and frame-valid towards the adder
//   sum_in, carry_in : adder result back into the sequencer
//   res_*  : captured result stream (valid/ready), res_data = {carry, sum}
// slave is the sequencer side; master is the producer/adder/consumer side.
interface bta_operand_sequencer_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 16,
  parameter int unsigned SW = M + $clog2(N) + 3
);
  logic           in_valid;
  logic           in_ready;
  logic [M-1:0]   in_data;
  logic           in_cin;
  logic [N*M-1:0] ops_bus;
  logic           ops_c0;
  logic           ops_valid;
  logic [SW-1:0]  sum_in;
  logic           carry_in;
  logic           res_valid;
  logic           res_ready;
  logic [SW:0]    res_data;

  modport slave (
    input  in_valid, in_data, in_cin, sum_in, carry_in, res_ready,
    output in_ready, ops_bus, ops_c0, ops_valid, res_valid, res_data
  );

  modport master (
    output in_valid, in_data, in_cin, sum_in, carry_in, res_ready,
    input  in_ready, ops_bus, ops_c0, ops_valid, res_valid, res_data
  );
endinterface

// File: rtl/bta_operand_sequencer.sv
// Operand sequencer in front of the N-operand binary tree adder.
// Collects N words one per handshake into parallel slots, holds them stable for the adder
// while waiting SUM_LAT cycles, captures {carry_in, sum_in}, and returns it on a result stream.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bta_operand_sequencer_if.slave (operand stream, adder bus, result stream)
module bta_operand_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned M       = 16,
  parameter int unsigned SUM_LAT = 0,
  parameter int unsigned SW      = M + $clog2(N) + 3
) (
  input logic                    clk,
  input logic                    rst,
  bta_operand_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(N);
  // Wait counter needs at least one bit even when the adder is combinational.
  localparam int unsigned WW = (SUM_LAT > 0) ? $clog2(SUM_LAT + 1) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);
  localparam logic [WW-1:0] LatMax  = WW'(SUM_LAT);

  typedef enum logic [1:0] {StFill, StIssue, StResult} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [N*M-1:0] ops_q, ops_d;
  logic           c0_q, c0_d;
  logic [SW:0]    res_q, res_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    ops_d   = ops_q;
    c0_d    = c0_q;
    res_d   = res_q;
    unique case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) ops_d[i*M +: M] = bus.in_data;
          end
          if (cnt_q == '0) c0_d = bus.in_cin;
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            wait_d  = '0;
            state_d = StIssue;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        if (wait_q == LatMax) begin
          res_d   = {bus.carry_in, bus.sum_in};
          wait_d  = '0;
          state_d = StResult;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StResult: begin
        if (bus.res_ready) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      cnt_q   <= '0;
      wait_q  <= '0;
      ops_q   <= '0;
      c0_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ops_q   <= ops_d;
      c0_q    <= c0_d;
      res_q   <= res_d;
    end
  end

  // State sits in FILL during reset, so in_ready is masked by rst to stay low until release.
  assign bus.in_ready  = (state_q == StFill) && !rst;
  assign bus.ops_valid = (state_q == StIssue);
  assign bus.res_valid = (state_q == StResult);
  assign bus.ops_bus   = ops_q;
  assign bus.ops_c0    = c0_q;
  assign bus.res_data  = res_q;

endmodule

// File: tb/tb_bta_operand_sequencer.sv
// Bench for bta_operand_sequencer: one instance with a combinational adder (SUM_LAT=0) and one
// with a 3-cycle pipelined adder (SUM_LAT=3). Expected frames and sums come from a queue model.
module tb_bta_operand_sequencer;
  localparam int unsigned N  = 8;
  localparam int unsigned M  = 16;
  localparam int unsigned SW = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bta_operand_sequencer_if #(.N(N), .M(M), .SW(SW)) b0 ();
  bta_operand_sequencer_if #(.N(N), .M(M), .SW(SW)) b1 ();

  bta_operand_sequencer #(.N(N), .M(M), .SUM_LAT(0), .SW(SW)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  bta_operand_sequencer #(.N(N), .M(M), .SUM_LAT(3), .SW(SW)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  // Adder models: plain sum of operands plus C0.
  logic [19:0] s0, s1, p1, p2, p3;
  always_comb begin
    s0 = 20'(b0.ops_c0);
    for (int i = 0; i < N; i++) s0 = s0 + 20'(b0.ops_bus[i*M +: M]);
  end
  always_comb begin
    s1 = 20'(b1.ops_c0);
    for (int i = 0; i < N; i++) s1 = s1 + 20'(b1.ops_bus[i*M +: M]);
  end
  always @(posedge clk) begin
    p1 <= s1;
    p2 <= p1;
    p3 <= p2;
  end
  assign b0.sum_in   = s0[18:0];
  assign b0.carry_in = s0[19];
  assign b1.sum_in   = p3[18:0];
  assign b1.carry_in = p3[19];

  // Reference model state for dut0.
  logic [15:0]  fw[$];
  logic         c_first;
  logic [19:0]  exp_q[$];
  logic [127:0] exp_bus = '0;
  logic         exp_c0 = 1'b0;
  time          acc_t[$];
  logic [15:0]  basic_w[8];
  logic [15:0]  wv[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One dut0 cycle, entered and left at a negedge; records handshakes into the model.
  task automatic step0();
    logic        acc_w, acc_r, c;
    logic [15:0] w;
    logic [19:0] r, s;
    time         t;
    acc_w = b0.in_valid && b0.in_ready;
    acc_r = b0.res_valid && b0.res_ready;
    w = b0.in_data;
    c = b0.in_cin;
    r = b0.res_data;
    t = $time;
    if (b0.ops_valid) begin
      chk("issue_bus", 64'(b0.ops_bus === exp_bus), 64'd1);
      chk("issue_c0", 64'(b0.ops_c0), 64'(exp_c0));
    end
    if (acc_r) begin
      chk("res_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("result", 64'(r), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (acc_w) begin
      if (fw.size() == 0) begin
        c_first = c;
        acc_t.push_back(t);
      end
      fw.push_back(w);
      if (fw.size() == N) begin
        s = 20'(c_first);
        for (int i = 0; i < N; i++) begin
          s = s + 20'(fw[i]);
          exp_bus[i*M +: M] = fw[i];
        end
        exp_q.push_back(s);
        exp_c0 = c_first;
        fw.delete();
      end
    end
    @(negedge clk);
  endtask

  // Present a word to dut0 and hold it until accepted; in_valid is left high.
  task automatic send0(input logic [15:0] w, input logic c);
    int n;
    n = 0;
    b0.in_data  = w;
    b0.in_cin   = c;
    b0.in_valid = 1'b1;
    while (!b0.in_ready && n < 100) begin
      step0();
      n++;
    end
    chk("send0_wait", 64'(n < 100), 64'd1);
    step0();
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step0();
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Feed wv[] to dut1 on consecutive cycles; later words carry the opposite cin.
  task automatic feed1(input logic c0);
    for (int i = 0; i < N; i++) begin
      b1.in_data  = wv[i];
      b1.in_cin   = (i == 0) ? c0 : ~c0;
      b1.in_valid = 1'b1;
      chk("feed1_ready", 64'(b1.in_ready), 64'd1);
      @(negedge clk);
    end
    b1.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bus0;
    logic [19:0]  held, e1;
    logic [15:0]  rb[8];
    int           n;
    basic_w = '{16'h5E3A, 16'hF0AE, 16'h5ACA, 16'h6B3E, 16'h593A, 16'h480E, 16'h39DA, 16'h5CBE};
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_cin = 1'b0; b0.res_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_cin = 1'b0; b1.res_ready = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_in_ready", 64'(b0.in_ready), 64'd0);
    chk("rst_ops_valid", 64'(b0.ops_valid), 64'd0);
    chk("rst_res_valid", 64'(b0.res_valid), 64'd0);
    chk("rst_res_data", 64'(b0.res_data), 64'd0);
    chk("rst_ops_bus", 64'(b0.ops_bus[63:0]), 64'd0);
    chk("rst_ops_c0", 64'(b0.ops_c0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready0", 64'(b0.in_ready), 64'd1);
    chk("rel_in_ready1", 64'(b1.in_ready), 64'd1);
    @(negedge clk);

    // Basic frame, combinational adder.
    b0.res_ready = 1'b1;
    for (int i = 0; i < N; i++) send0(basic_w[i], 1'b0);
    b0.in_valid = 1'b0;
    chk("basic_ops_valid", 64'(b0.ops_valid), 64'd1);
    chk("basic_word0", 64'(b0.ops_bus[15:0]), 64'h5E3A);
    chk("basic_word7", 64'(b0.ops_bus[127:112]), 64'h5CBE);
    step0();
    chk("basic_ops_valid_1cyc", 64'(b0.ops_valid), 64'd0);
    chk("basic_res_valid", 64'(b0.res_valid), 64'd1);
    chk("basic_res_data", 64'(b0.res_data), 64'h34CD0);
    step0();
    chk("basic_back_to_fill", 64'(b0.in_ready), 64'd1);

    // Latency: pipelined adder on dut1.
    for (int i = 0; i < N; i++) wv[i] = basic_w[i];
    e1 = '0;
    for (int i = 0; i < N; i++) e1 = e1 + 20'(wv[i]);
    feed1(1'b0);
    bus0 = b1.ops_bus;
    chk("lat_word7", 64'(bus0[127:112]), 64'(wv[7]));
    n = 0;
    while (b1.ops_valid && n < 20) begin
      chk("lat_bus_stable", 64'(b1.ops_bus === bus0), 64'd1);
      @(negedge clk);
      n++;
    end
    chk("lat_issue_cycles", 64'(n), 64'd4);
    chk("lat_res_valid", 64'(b1.res_valid), 64'd1);
    chk("lat_res_data", 64'(b1.res_data), 64'(e1));
    b1.res_ready = 1'b1;
    @(negedge clk);
    b1.res_ready = 1'b0;
    chk("lat_back_to_fill", 64'(b1.in_ready), 64'd1);

    // Backpressure: result held 10 cycles while the producer keeps in_valid high.
    b0.res_ready = 1'b0;
    for (int i = 0; i < N; i++) rb[i] = 16'($urandom);
    for (int i = 0; i < N; i++) send0(16'($urandom), 1'($urandom));
    b0.in_data = rb[0];
    n = 0;
    while (!b0.res_valid && n < 20) begin
      step0();
      n++;
    end
    chk("bp_res_valid", 64'(b0.res_valid), 64'd1);
    held = b0.res_data;
    chk("bp_res_model", 64'(held), 64'(exp_q[0]));
    repeat (10) begin
      chk("bp_in_ready", 64'(b0.in_ready), 64'd0);
      chk("bp_res_stable", 64'(b0.res_data), 64'(held));
      step0();
    end
    b0.res_ready = 1'b1;
    step0();
    chk("bp_release_ready", 64'(b0.in_ready), 64'd1);
    for (int i = 0; i < N; i++) send0(rb[i], 1'($urandom));
    b0.in_valid = 1'b0;
    drain0();

    // Carry-in with in_valid toggling every other cycle.
    for (int i = 0; i < N; i++) begin
      send0(16'hFFFF, (i == 0));
      b0.in_valid = 1'b0;
      step0();
    end
    chk("cin_res_valid", 64'(b0.res_valid), 64'd1);
    chk("cin_res_data", 64'(b0.res_data), 64'h7FFF9);
    chk("cin_c0", 64'(b0.ops_c0), 64'd1);
    drain0();

    // Back-to-back random frames, res_ready tied high.
    acc_t.delete();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) send0(16'($urandom), 1'($urandom));
    b0.in_valid = 1'b0;
    drain0();
    chk("b2b_frames", 64'(acc_t.size()), 64'd4);
    for (int f = 1; f < acc_t.size(); f++) chk("b2b_period", 64'(acc_t[f] - acc_t[f-1]), 64'd100);

    // Asynchronous reset in the middle of ISSUE on dut1.
    for (int i = 0; i < N; i++) wv[i] = 16'($urandom_range(1, 16'hFFFF));
    feed1(1'b1);
    @(negedge clk);
    chk("mid_issue", 64'(b1.ops_valid), 64'd1);
    chk("mid_issue_c0", 64'(b1.ops_c0), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ops_valid", 64'(b1.ops_valid), 64'd0);
    chk("arst_res_valid", 64'(b1.res_valid), 64'd0);
    chk("arst_ops_bus_lo", 64'(b1.ops_bus[63:0]), 64'd0);
    chk("arst_ops_bus_hi", 64'(b1.ops_bus[127:64]), 64'd0);
    chk("arst_res_data1", 64'(b1.res_data), 64'd0);
    chk("arst_res_data0", 64'(b0.res_data), 64'd0);
    chk("arst_ops_c0", 64'(b1.ops_c0), 64'd0);
    chk("arst_in_ready", 64'(b1.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 64'(b1.in_ready), 64'd1);
    @(negedge clk);
    b1.in_data  = 16'hA5C3;
    b1.in_cin   = 1'b0;
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("restart_slot0", 64'(b1.ops_bus[15:0]), 64'hA5C3);
    chk("restart_slot1", 64'(b1.ops_bus[31:16]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
